axis_pkt_fifo: RTL and testbench

Parametrised AXI4-Stream FIFO with tkeep/tlast sideband, an optional store-and-forward packet mode, an occupancy count and an almost-full flag. It sits between the LBUS/AXIS converters and the packet-processing stages. It supersedes the single-word-data FIFO wherever frame boundaries must be preserved or a downstream stage needs whole packets before it starts.

---
 rtl/axis_pkt_fifo_pkg.sv | 25 ++
 rtl/axis_pkt_fifo_if.sv | 16 +
 rtl/axis_pkt_fifo_sdp_ram.sv | 23 ++
 rtl/axis_pkt_fifo.sv | 152 +++++++++++++++
 tb/tb_axis_pkt_fifo.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkt_fifo_pkg.sv
// Shared types, mode constants and width helpers for the AXI4-Stream packet FIFO.
// Imported by the interface and the FIFO top level.
package axis_fifo_pkg;

    localparam int unsigned MODE_STREAM    = 0;
    localparam int unsigned MODE_PKT       = 1;
    localparam int unsigned DWIDTH_DEFAULT = 512;

    // Entry layout at the default bus width. The top level builds the same layout at its own DWIDTH.
    typedef struct packed {
        logic [DWIDTH_DEFAULT-1:0]   tdata;
        logic [DWIDTH_DEFAULT/8-1:0] tkeep;
        logic                        tlast;
    } fifo_entry_t;

    // One extra MSB tells full apart from empty.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int unsigned entry_w(input int unsigned dwidth);
        return dwidth + dwidth / 8 + 1;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo_if.sv
// AXI4-Stream beat bundle carrying tdata, tkeep and tlast.
// Master drives the beat; slave returns tready.
interface axis_pkt_fifo_if
    import axis_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH = DWIDTH_DEFAULT
);
    logic [DWIDTH-1:0]   tdata;
    logic [DWIDTH/8-1:0] tkeep;
    logic                tlast;
    logic                tvalid;
    logic                tready;

    modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_pkt_fifo_sdp_ram.sv
// Simple dual-port LUTRAM: synchronous write port, asynchronous read port.
// Contents are intentionally not reset.
module fifo_sdp_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/axis_pkt_fifo.sv
// AXI4-Stream FIFO that keeps tkeep/tlast. It has a registered output stage and an optional
// store-and-forward packet mode, which breaks deadlock on packets too large for the storage.
module axis_pkt_fifo
    import axis_fifo_pkg::*;
#(
    parameter int unsigned DWIDTH       = 512,
    parameter int unsigned DEPTH        = 32,
    parameter int unsigned PKT_MODE     = MODE_STREAM,
    parameter int unsigned AFULL_THRESH = DEPTH - 4
) (
    input  logic                   clk,
    input  logic                   rst,
    axis_pkt_fifo_if.slave         s_axis,
    axis_pkt_fifo_if.master        m_axis,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full,
    output logic                   oversize
);
    localparam int unsigned KW  = DWIDTH / 8;
    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned PW  = ptr_w(DEPTH);
    localparam int unsigned EW  = entry_w(DWIDTH);
    localparam bit          PKT = (PKT_MODE == MODE_PKT);

    typedef struct packed {
        logic [DWIDTH-1:0] tdata;
        logic [KW-1:0]     tkeep;
        logic              tlast;
    } entry_t;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          full_q, full_d;
    logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
    logic          bypass_q, bypass_d;
    logic [PW-1:0] count_q, count_d;
    logic          afull_q, afull_d;
    logic          oversize_q, oversize_d;
    entry_t        out_q, out_d;
    logic          out_valid_q, out_valid_d;

    logic          wr_en, rd_en, empty, readable, core_rdy, out_hs;
    logic          pkt_inc, pkt_dec, deadlock;
    entry_t        wr_entry, rd_entry;
    logic [EW-1:0] ram_rdata;

    assign wr_entry = '{tdata: s_axis.tdata, tkeep: s_axis.tkeep, tlast: s_axis.tlast};
    assign rd_entry = entry_t'(ram_rdata);

    fifo_sdp_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (wr_entry),
        .raddr (rd_ptr_q[AW-1:0]),
        .rdata (ram_rdata)
    );

    // Handshakes and storage pointers
    always_comb begin
        wr_en    = s_axis.tvalid && !full_q;
        empty    = (wr_ptr_q == rd_ptr_q);
        readable = !empty && (!PKT || (pkt_cnt_q != '0) || bypass_q);
        core_rdy = m_axis.tready || !out_valid_q;
        rd_en    = core_rdy && readable;
        out_hs   = out_valid_q && m_axis.tready;

        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        rd_ptr_d = rd_ptr_q + PW'(rd_en);
        full_d   = (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]) && (wr_ptr_d[AW] != rd_ptr_d[AW]);
    end

    // Complete-packet accounting and the oversize bypass
    always_comb begin
        pkt_inc  = wr_en && s_axis.tlast;
        pkt_dec  = rd_en && rd_entry.tlast;
        deadlock = PKT && full_q && (pkt_cnt_q == '0) && !bypass_q;

        pkt_cnt_d = pkt_cnt_q;
        if (pkt_inc && !pkt_dec) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end else if (!pkt_inc && pkt_dec) begin
            pkt_cnt_d = pkt_cnt_q - 1'b1;
        end

        bypass_d = bypass_q;
        if (deadlock) begin
            bypass_d = 1'b1;
        end else if (bypass_q && pkt_dec) begin
            bypass_d = 1'b0;
        end
        oversize_d = deadlock;
    end

    // Occupancy, threshold flag and output register
    always_comb begin
        count_d = count_q;
        if (wr_en && !out_hs) begin
            count_d = count_q + 1'b1;
        end else if (!wr_en && out_hs) begin
            count_d = count_q - 1'b1;
        end
        afull_d = (count_d >= PW'(AFULL_THRESH));

        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (rd_en) begin
            out_d       = rd_entry;
            out_valid_d = 1'b1;
        end else if (core_rdy) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            full_q      <= 1'b0;
            pkt_cnt_q   <= '0;
            bypass_q    <= 1'b0;
            count_q     <= '0;
            afull_q     <= 1'b0;
            oversize_q  <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            full_q      <= full_d;
            pkt_cnt_q   <= pkt_cnt_d;
            bypass_q    <= bypass_d;
            count_q     <= count_d;
            afull_q     <= afull_d;
            oversize_q  <= oversize_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign s_axis.tready = !full_q;
    assign m_axis.tdata  = out_q.tdata;
    assign m_axis.tkeep  = out_q.tkeep;
    assign m_axis.tlast  = out_q.tlast;
    assign m_axis.tvalid = out_valid_q;
    assign count         = count_q;
    assign almost_full   = afull_q;
    assign oversize      = oversize_q;
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Directed bench for axis_pkt_fifo: a stream-mode instance (DEPTH=16) and a packet-mode
// instance (DEPTH=8), each checked against a scoreboard queue and an occupancy model.
module tb_axis_pkt_fifo;
    import axis_fifo_pkg::*;

    localparam int unsigned DW = 32;
    localparam int unsigned THR_S = 12;
    localparam int unsigned THR_P = 4;

    logic clk = 1'b0;
    logic rst_s, rst_p;
    logic [4:0] cnt_s;
    logic [3:0] cnt_p;
    logic af_s, af_p, ov_s, ov_p;

    axis_pkt_fifo_if #(.DWIDTH(DW)) s_str ();
    axis_pkt_fifo_if #(.DWIDTH(DW)) m_str ();
    axis_pkt_fifo_if #(.DWIDTH(DW)) s_pkt ();
    axis_pkt_fifo_if #(.DWIDTH(DW)) m_pkt ();

    axis_pkt_fifo #(.DWIDTH(DW), .DEPTH(16), .PKT_MODE(MODE_STREAM)) u_str (
        .clk(clk), .rst(rst_s), .s_axis(s_str), .m_axis(m_str),
        .count(cnt_s), .almost_full(af_s), .oversize(ov_s));

    axis_pkt_fifo #(.DWIDTH(DW), .DEPTH(8), .PKT_MODE(MODE_PKT)) u_pkt (
        .clk(clk), .rst(rst_p), .s_axis(s_pkt), .m_axis(m_pkt),
        .count(cnt_p), .almost_full(af_p), .oversize(ov_p));

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;
    logic [36:0] q_str[$];
    logic [36:0] q_pkt[$];
    logic [36:0] stim_p[$];
    int mcnt_s = 0, mcnt_p = 0;
    bit acc_s, acc_p;
    int pop_s = 0, pop_p = 0, ovs_s = 0, ovs_p = 0;
    int cyc = 0, first_s = -1, last_s = -1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [36:0] mkbeat(input bit last);
        logic [31:0] d;
        logic [3:0]  k;
        d = $urandom;
        k = 4'($urandom_range(1, 15));
        return {d, k, last};
    endfunction

    task automatic put_s(input logic [36:0] b);
        s_str.tdata = b[36:5]; s_str.tkeep = b[4:1]; s_str.tlast = b[0]; s_str.tvalid = 1'b1;
    endtask

    task automatic put_p(input logic [36:0] b);
        s_pkt.tdata = b[36:5]; s_pkt.tkeep = b[4:1]; s_pkt.tlast = b[0]; s_pkt.tvalid = 1'b1;
    endtask

    // Handshakes are judged at the falling edge, where inputs and registered outputs are stable.
    task automatic step();
        logic [36:0] exp;
        @(negedge clk);
        acc_s = s_str.tvalid && s_str.tready;
        acc_p = s_pkt.tvalid && s_pkt.tready;
        if (acc_s) begin q_str.push_back({s_str.tdata, s_str.tkeep, s_str.tlast}); mcnt_s++; end
        if (acc_p) begin q_pkt.push_back({s_pkt.tdata, s_pkt.tkeep, s_pkt.tlast}); mcnt_p++; end
        if (ov_s) ovs_s++;
        if (ov_p) ovs_p++;
        if (m_str.tvalid && m_str.tready) begin
            pop_s++; mcnt_s--;
            if (first_s < 0) first_s = cyc;
            last_s = cyc;
            chk("str_beat_expected", 64'(q_str.size() != 0), 64'd1);
            if (q_str.size() != 0) begin
                exp = q_str.pop_front();
                chk("str_beat", {m_str.tdata, m_str.tkeep, m_str.tlast}, exp);
            end
        end
        if (m_pkt.tvalid && m_pkt.tready) begin
            pop_p++; mcnt_p--;
            chk("pkt_beat_expected", 64'(q_pkt.size() != 0), 64'd1);
            if (q_pkt.size() != 0) begin
                exp = q_pkt.pop_front();
                chk("pkt_beat", {m_pkt.tdata, m_pkt.tkeep, m_pkt.tlast}, exp);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        chk("str_count", 64'(cnt_s), 64'(mcnt_s));
        chk("str_afull", 64'(af_s), 64'(mcnt_s >= int'(THR_S)));
        chk("pkt_count", 64'(cnt_p), 64'(mcnt_p));
        chk("pkt_afull", 64'(af_p), 64'(mcnt_p >= int'(THR_P)));
        chk("str_oversize", 64'(ov_s), 64'd0);
    endtask

    // Drives every beat in stim_p, then drains the packet FIFO completely.
    task automatic run_pkt(input bit rnd, input int unsigned budget);
        int unsigned left;
        left = budget;
        while (stim_p.size() != 0 && left != 0) begin
            put_p(stim_p[0]);
            if (rnd) m_pkt.tready = 1'($urandom_range(0, 1));
            step();
            if (acc_p) void'(stim_p.pop_front());
            left--;
        end
        s_pkt.tvalid = 1'b0;
        while ((q_pkt.size() != 0 || m_pkt.tvalid) && left != 0) begin
            if (rnd) m_pkt.tready = 1'($urandom_range(0, 1));
            step();
            left--;
        end
        chk("pkt_run_within_budget", 64'(left != 0), 64'd1);
        m_pkt.tready = 1'b1;
    endtask

    initial begin
        logic [36:0] b;
        int nacc;
        int p0;

        s_str.tvalid = 1'b0; s_str.tdata = '0; s_str.tkeep = '0; s_str.tlast = 1'b0;
        s_pkt.tvalid = 1'b0; s_pkt.tdata = '0; s_pkt.tkeep = '0; s_pkt.tlast = 1'b0;
        m_str.tready = 1'b0; m_pkt.tready = 1'b0;
        rst_s = 1'b1; rst_p = 1'b1;
        step(); step();

        chk("rst_str_tvalid", 64'(m_str.tvalid), 64'd0);
        chk("rst_str_out", {m_str.tdata, m_str.tkeep, m_str.tlast}, 64'd0);
        chk("rst_str_tready", 64'(s_str.tready), 64'd1);
        chk("rst_pkt_tvalid", 64'(m_pkt.tvalid), 64'd0);
        chk("rst_pkt_out", {m_pkt.tdata, m_pkt.tkeep, m_pkt.tlast}, 64'd0);
        chk("rst_pkt_tready", 64'(s_pkt.tready), 64'd1);
        chk("rst_pkt_oversize", 64'(ov_p), 64'd0);
        rst_s = 1'b0; rst_p = 1'b0;

        // Stream fill: 16 storage entries plus the output register accept beats.
        nacc = 0;
        b = mkbeat(1'b0);
        for (int i = 0; i < 25; i++) begin
            if (nacc < 20) put_s(b); else s_str.tvalid = 1'b0;
            step();
            if (acc_s) begin nacc++; b = mkbeat(nacc % 4 == 3); end
        end
        chk("fill_accepted", 64'(nacc), 64'd17);
        chk("fill_tready_low", 64'(s_str.tready), 64'd0);
        chk("fill_count", 64'(cnt_s), 64'd17);
        chk("fill_afull", 64'(af_s), 64'd1);

        s_str.tvalid = 1'b0;
        m_str.tready = 1'b1;
        pop_s = 0;
        for (int i = 0; i < 40 && (q_str.size() != 0 || m_str.tvalid); i++) step();
        chk("fill_drained", 64'(pop_s), 64'd17);
        chk("fill_drained_tready", 64'(s_str.tready), 64'd1);

        // Continuous traffic across the pointer wrap.
        nacc = 0; pop_s = 0; first_s = -1; last_s = -1;
        b = mkbeat(1'b0);
        for (int i = 0; i < 35; i++) begin
            put_s(b);
            step();
            if (acc_s) begin nacc++; b = mkbeat(nacc % 7 == 6); end
        end
        s_str.tvalid = 1'b0;
        repeat (4) step();
        chk("wrap_no_input_stall", 64'(nacc), 64'd35);
        chk("wrap_beats_out", 64'(pop_s), 64'd35);
        chk("wrap_no_output_bubble", 64'(last_s - first_s + 1), 64'd35);
        chk("wrap_queue_empty", 64'(q_str.size()), 64'd0);

        // Packet latency: four beats, a three-cycle gap, then the tlast beat.
        m_pkt.tready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            put_p(mkbeat(1'b0));
            step();
            chk("lat_head_accepted", 64'(acc_p), 64'd1);
            chk("lat_held_before_tlast", 64'(m_pkt.tvalid), 64'd0);
        end
        s_pkt.tvalid = 1'b0;
        repeat (3) begin
            step();
            chk("lat_held_in_gap", 64'(m_pkt.tvalid), 64'd0);
        end
        put_p(mkbeat(1'b1));
        step();
        chk("lat_tlast_accepted", 64'(acc_p), 64'd1);
        chk("lat_edge_n", 64'(m_pkt.tvalid), 64'd0);
        s_pkt.tvalid = 1'b0;
        step();
        chk("lat_edge_n1", 64'(m_pkt.tvalid), 64'd1);
        p0 = pop_p;
        repeat (5) step();
        chk("lat_back_to_back", 64'(pop_p - p0), 64'd5);
        chk("lat_done_tvalid", 64'(m_pkt.tvalid), 64'd0);

        // Back-to-back 1/2/3-beat packets against a random sink.
        for (int r = 0; r < 3; r++)
            for (int sz = 1; sz <= 3; sz++)
                for (int k = 0; k < sz; k++) stim_p.push_back(mkbeat(k == sz - 1));
        p0 = pop_p; ovs_p = 0;
        run_pkt(1'b1, 300);
        chk("mix_beats_out", 64'(pop_p - p0), 64'd18);
        chk("mix_pkt_cnt", 64'(u_pkt.pkt_cnt_q), 64'd0);
        chk("mix_count", 64'(cnt_p), 64'd0);
        chk("mix_no_oversize", 64'(ovs_p), 64'd0);

        // A 12-beat packet cannot fit in 8 entries and must be released cut-through.
        for (int k = 0; k < 12; k++) stim_p.push_back(mkbeat(k == 11));
        p0 = pop_p; ovs_p = 0;
        run_pkt(1'b0, 100);
        chk("big_beats_out", 64'(pop_p - p0), 64'd12);
        chk("big_oversize_once", 64'(ovs_p), 64'd1);
        chk("big_bypass_clear", 64'(u_pkt.bypass_q), 64'd0);
        chk("big_count", 64'(cnt_p), 64'd0);

        // Reset with half a packet stored, then a clean 2-beat packet.
        nacc = 0;
        b = mkbeat(1'b0);
        for (int i = 0; i < 10 && nacc < 3; i++) begin
            put_p(b);
            step();
            if (acc_p) begin nacc++; b = mkbeat(1'b0); end
        end
        chk("rstmid_partial_written", 64'(nacc), 64'd3);
        s_pkt.tvalid = 1'b0;
        m_pkt.tready = 1'b0;
        rst_p = 1'b1;
        q_pkt.delete();
        mcnt_p = 0;
        step(); step();
        rst_p = 1'b0;
        chk("rstmid_tvalid", 64'(m_pkt.tvalid), 64'd0);
        chk("rstmid_count", 64'(cnt_p), 64'd0);
        chk("rstmid_tready", 64'(s_pkt.tready), 64'd1);
        m_pkt.tready = 1'b1;
        stim_p.push_back(mkbeat(1'b0));
        stim_p.push_back(mkbeat(1'b1));
        p0 = pop_p;
        run_pkt(1'b0, 40);
        chk("rstmid_beats_out", 64'(pop_p - p0), 64'd2);
        chk("rstmid_pkt_cnt", 64'(u_pkt.pkt_cnt_q), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
